neuron_mac_seq: RTL and testbench
=================================

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 SHALL have parameter N_IN, default 784: number of weight/pixel pairs per neuron.
REQ-002 SHALL have parameter LANES, default 7: multipliers per cycle; N_IN % LANES == 0 is required; CHUNKS = N_IN/LANES.
REQ-003 SHALL have parameter W_W, default 19: signed weight and bias width.
REQ-004 SHALL have parameter P_W, default 10: unsigned pixel width.
REQ-005 SHALL have parameter ACC_W, default 26: signed accumulator and result width.
REQ-006 SHALL have parameter SHIFT, default 3: arithmetic right shift applied to each product.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 GlobalReset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  request one neuron evaluation.
REQ-010 relu_en  input  1  mode: 1 = clamp negative results to 0; sampled when start is accepted.
REQ-011 WX  input  N_IN*W_W+W_W  bias at [W_W-1:0]; weight i at [W_W*(i+2)-1 : W_W*(i+1)].
REQ-012 PIXEL  input  N_IN*P_W  pixel i at [P_W*(i+1)-1 : P_W*i].
REQ-013 busy  output  1  high from start acceptance until the result is taken.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 Out_X  output  ACC_W  signed neuron result.
REQ-017 sat_flag  output  1  set if any accumulation, or the bias add, saturated during this evaluation.

Function
REQ-018 SHALL implement the FSM IDLE -> RUN -> DRAIN -> BIAS -> DONE -> IDLE.
REQ-019 IDLE: start=1 SHALL be accepted; it clears the accumulator, chunk counter and sat_flag, latches relu_en, asserts busy and enters RUN.
REQ-020 RUN: SHALL select chunk k (pairs k*LANES .. k*LANES+LANES-1), register the LANES products, and increment k; after k = CHUNKS-1 it SHALL enter DRAIN.
REQ-021 Each product SHALL be signed weight x zero-extended pixel, full precision, then arithmetic-shifted right by SHIFT.
REQ-022 One edge after each product register load, the LANES shifted products SHALL be summed at full width and added to the accumulator, saturating to the signed ACC_W range.
REQ-023 DRAIN: SHALL perform the final chunk accumulation.
REQ-024 BIAS: SHALL add the sign-extended bias with saturation, then apply ReLU if the latched relu_en=1, and register the result into Out_X.
REQ-025 DONE: SHALL hold out_valid=1 with Out_X and sat_flag stable until out_valid & out_ready; on that edge it SHALL return to IDLE and drop busy and out_valid.
REQ-026 Latency: out_valid SHALL rise exactly CHUNKS+3 rising edges after the start-accepting edge.
REQ-027 start while busy SHALL be ignored (no queueing, no restart).
REQ-028 out_ready while out_valid=0 SHALL be ignored.
REQ-029 WX, PIXEL and relu_en SHALL be required stable while busy; no internal copy is taken.
REQ-030 Once saturated, the accumulator SHALL continue accumulating from the clamped value (no sticky clamp); sat_flag SHALL remain set.
REQ-031 CHUNKS = 1 SHALL be legal: RUN lasts one cycle.

Reset
REQ-032 GlobalReset=1 SHALL force, on the next edge: state IDLE, Out_X=0, out_valid=0, busy=0, sat_flag=0, accumulator=0, chunk counter=0, product registers=0.
REQ-033 Reset SHALL take priority over start and out_ready; reset mid-evaluation SHALL abort with no out_valid pulse.

Structure
REQ-034 The FSM state enum, the default parameter values and a saturating-add function SHALL live in shared package neuron_pkg.
REQ-035 The LANES-wide multiply, shift and product register stage SHALL be a sub-module named neuron_lane_mult; the FSM, accumulator and output stage SHALL stay in the top.

Verification (N_IN=14, LANES=7, W_W=19, P_W=10, ACC_W=26, SHIFT=0 unless stated)
REQ-036 All weights 1, all pixels 1, bias 0, relu_en=0, start pulse -> out_valid exactly 5 edges later, Out_X=14, sat_flag=0.
REQ-037 All weights -2, pixels 3, bias 10, relu_en=0 -> Out_X=-74; repeat with relu_en=1 -> Out_X=0.
REQ-038 ACC_W=20, all weights 262143, pixels 1023 -> Out_X=524287, sat_flag=1.
REQ-039 Hold out_ready=0 for 10 cycles after out_valid, pulsing start during that window -> Out_X and out_valid stable, start ignored; out_ready=1 -> IDLE next edge, busy=0.
REQ-040 GlobalReset asserted on the 2nd RUN cycle -> all outputs 0 next edge; a fresh start then yields the correct result with latency 5.
REQ-041 Default parameters, SHIFT=3, random vectors -> Out_X matches a reference model; latency = 115.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC: default sizes, FSM states and
// the saturating adder used by the accumulator and the bias stage.
package neuron_pkg;
    localparam int N_IN_DEF  = 784;
    localparam int LANES_DEF = 7;
    localparam int W_W_DEF   = 19;
    localparam int P_W_DEF   = 10;
    localparam int ACC_W_DEF = 26;
    localparam int SHIFT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_res_t;

    // a + b clamped to the signed range of width w (w <= 63); operands are
    // small enough that the 64-bit sum itself never wraps.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned w);
        logic signed [63:0] s, hi, lo;
        sat_res_t r;
        s     = a + b;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.val = s;
        r.sat = 1'b0;
        if (s > hi) begin
            r.val = hi;
            r.sat = 1'b1;
        end else if (s < lo) begin
            r.val = lo;
            r.sat = 1'b1;
        end
        return r;
    endfunction
endpackage

// File: rtl/neuron_lane_mult.sv
// LANES parallel signed-weight x unsigned-pixel multipliers with the
// arithmetic shift folded in, feeding a registered product bank.
module neuron_lane_mult
    import neuron_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int P_W   = P_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int PR_W  = W_W + P_W + 1
) (
    input  logic                             clk,
    input  logic                             GlobalReset,
    input  logic                             load,
    input  logic [LANES-1:0][W_W-1:0]        lane_w,
    input  logic [LANES-1:0][P_W-1:0]        lane_px,
    output logic [LANES-1:0][PR_W-1:0]       prod
);
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [PR_W-1:0] p_full;

        // Pixel gets a zero sign bit so it multiplies as a non-negative value.
        always_comb begin
            p_full = PR_W'(signed'(lane_w[j])) * PR_W'(signed'({1'b0, lane_px[j]}));
        end

        // Product register, loaded once per chunk while running.
        always_ff @(posedge clk) begin
            if (GlobalReset)
                prod[j] <= '0;
            else if (load)
                prod[j] <= p_full >>> SHIFT;
        end
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: streams N_IN weight/pixel pairs LANES at a time into a
// saturating accumulator, adds the bias, optionally applies ReLU, and holds
// the result under a valid/ready handshake.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int LANES = LANES_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic                       clk,
    input  logic                       GlobalReset,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic [N_IN*W_W+W_W-1:0]    WX,
    input  logic [N_IN*P_W-1:0]        PIXEL,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    Out_X,
    output logic                       sat_flag
);
    localparam int CHUNKS = N_IN / LANES;
    localparam int CK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PR_W   = W_W + P_W + 1;
    localparam int SUM_W  = PR_W + $clog2(LANES) + 1;

    state_t                      state;
    logic [CK_W-1:0]             k;
    logic                        relu_q;
    logic                        prod_vld;
    logic                        load;
    logic signed [ACC_W-1:0]     acc;
    logic [LANES-1:0][W_W-1:0]   lane_w;
    logic [LANES-1:0][P_W-1:0]   lane_px;
    logic [LANES-1:0][PR_W-1:0]  prod;
    logic signed [SUM_W-1:0]     lane_sum;
    sat_res_t                    acc_nxt;
    sat_res_t                    bias_nxt;
    logic signed [ACC_W-1:0]     bias_res;
    logic signed [ACC_W-1:0]     result;
    logic                        unused_hi;

    assign load = (state == ST_RUN);

    // Pick the current chunk of weights (offset by the bias slot) and pixels.
    always_comb begin
        lane_w  = '0;
        lane_px = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_w[j]  = WX[W_W*(int'(k)*LANES + j + 1) +: W_W];
            lane_px[j] = PIXEL[P_W*(int'(k)*LANES + j) +: P_W];
        end
    end

    neuron_lane_mult #(
        .LANES (LANES),
        .W_W   (W_W),
        .P_W   (P_W),
        .SHIFT (SHIFT),
        .PR_W  (PR_W)
    ) u_mult (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .load        (load),
        .lane_w      (lane_w),
        .lane_px     (lane_px),
        .prod        (prod)
    );

    // Full-width lane reduction, then saturating accumulate and bias add.
    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++)
            lane_sum = lane_sum + SUM_W'(signed'(prod[j]));
        acc_nxt  = sat_add(64'(acc), 64'(lane_sum), ACC_W);
        bias_nxt = sat_add(64'(acc), 64'(signed'(WX[W_W-1:0])), ACC_W);
        bias_res = bias_nxt.val[ACC_W-1:0];
        result   = (relu_q && bias_res < 0) ? '0 : bias_res;
    end

    // Clamped values always fit ACC_W; the upper bits are sign copies.
    assign unused_hi = ^{acc_nxt.val[63:ACC_W], bias_nxt.val[63:ACC_W]};

    // Control FSM, accumulator and output register. out_valid is asserted
    // one cycle into DONE, giving the output stage its own register slot.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state     <= ST_IDLE;
            k         <= '0;
            acc       <= '0;
            prod_vld  <= 1'b0;
            relu_q    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            Out_X     <= '0;
            sat_flag  <= 1'b0;
        end else begin
            prod_vld <= load;
            if (prod_vld) begin
                acc <= acc_nxt.val[ACC_W-1:0];
                if (acc_nxt.sat)
                    sat_flag <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        k        <= '0;
                        sat_flag <= 1'b0;
                        relu_q   <= relu_en;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    k <= k + 1'b1;
                    if (k == CK_W'(CHUNKS - 1))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_BIAS;
                ST_BIAS: begin
                    Out_X <= result;
                    if (bias_nxt.sat)
                        sat_flag <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: two small instances (ACC_W 26 and 20) share
// stimulus for the table vectors and corner sequences; a default-size
// instance is checked against a reference model with random vectors.
module tb_neuron_mac_seq;
    localparam int NA = 14, LA = 7, WW = 19, PW = 10;
    localparam int NC = 784, LC = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic                    ab_start, ab_relu, ab_ready;
    logic [NA*WW+WW-1:0]     ab_wx;
    logic [NA*PW-1:0]        ab_px;
    logic                    a_busy, a_valid, a_sat, b_busy, b_valid, b_sat;
    logic signed [25:0]      a_out;
    logic signed [19:0]      b_out;

    logic                    c_start, c_relu, c_ready, c_busy, c_valid, c_sat;
    logic [NC*WW+WW-1:0]     c_wx;
    logic [NC*PW-1:0]        c_px;
    logic signed [25:0]      c_out;

    neuron_mac_seq #(.N_IN(NA), .LANES(LA), .W_W(WW), .P_W(PW), .ACC_W(26), .SHIFT(0)) u_a (
        .clk(clk), .GlobalReset(rst), .start(ab_start), .relu_en(ab_relu), .WX(ab_wx), .PIXEL(ab_px),
        .busy(a_busy), .out_valid(a_valid), .out_ready(ab_ready), .Out_X(a_out), .sat_flag(a_sat));

    neuron_mac_seq #(.N_IN(NA), .LANES(LA), .W_W(WW), .P_W(PW), .ACC_W(20), .SHIFT(0)) u_b (
        .clk(clk), .GlobalReset(rst), .start(ab_start), .relu_en(ab_relu), .WX(ab_wx), .PIXEL(ab_px),
        .busy(b_busy), .out_valid(b_valid), .out_ready(ab_ready), .Out_X(b_out), .sat_flag(b_sat));

    neuron_mac_seq u_c (
        .clk(clk), .GlobalReset(rst), .start(c_start), .relu_en(c_relu), .WX(c_wx), .PIXEL(c_px),
        .busy(c_busy), .out_valid(c_valid), .out_ready(c_ready), .Out_X(c_out), .sat_flag(c_sat));

    typedef struct {
        string  name;
        int     w;
        int     px;
        int     bias;
        bit     relu;
        longint ea;
        bit     sa;
        longint eb;
        bit     sb;
    } vec_t;

    typedef struct {
        longint res;
        bit     sat;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    int   n_chk = 0, n_pass = 0;
    int   w_arr[NC], px_arr[NC], c_bias;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Weights of the first chunk = w_lo, second chunk = w_hi.
    task automatic drive_ab(input int w_lo, input int w_hi, input int px, input int bias, input bit relu);
        ab_wx[WW-1:0] = WW'(bias);
        for (int i = 0; i < NA; i++) begin
            ab_wx[WW*(i+1) +: WW] = WW'((i < LA) ? w_lo : w_hi);
            ab_px[PW*i +: PW]     = PW'(px);
        end
        ab_relu = relu;
    endtask

    task automatic run_ab(input string nm, input longint ea, input bit sa, input longint eb, input bit sb,
                          input int hold, input bit early_ready);
        exp_t ex_a, ex_b;
        int   n;
        q_a.push_back('{ea, sa});
        q_b.push_back('{eb, sb});
        @(negedge clk);
        ab_start = 1'b1;
        ab_ready = early_ready;
        @(negedge clk);
        ab_start = 1'b0;
        n = 0;
        while (!a_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 5);
        chk({nm, " b_valid"}, b_valid, 1);
        ex_a = q_a.pop_front();
        ex_b = q_b.pop_front();
        chk({nm, " a_out"}, a_out, ex_a.res);
        chk({nm, " a_sat"}, a_sat, ex_a.sat);
        chk({nm, " b_out"}, b_out, ex_b.res);
        chk({nm, " b_sat"}, b_sat, ex_b.sat);
        for (int c = 0; c < hold; c++) begin
            ab_start = (c == 3);
            @(negedge clk);
            chk({nm, " hold valid"}, a_valid, 1);
            chk({nm, " hold out"}, a_out, ex_a.res);
        end
        ab_start = 1'b0;
        ab_ready = 1'b1;
        @(negedge clk);
        ab_ready = 1'b0;
        chk({nm, " a_busy after"}, a_busy, 0);
        chk({nm, " a_valid after"}, a_valid, 0);
        chk({nm, " b_busy after"}, b_busy, 0);
    endtask

    function automatic void model(input int n, input int lanes, input int shift, input int accw,
                                  input bit relu, output longint res, output bit sat);
        longint acc, s, hi, lo;
        acc = 0;
        sat = 0;
        hi  = (64'sd1 <<< (accw - 1)) - 1;
        lo  = -(64'sd1 <<< (accw - 1));
        for (int k = 0; k < n / lanes; k++) begin
            s = 0;
            for (int j = 0; j < lanes; j++)
                s += (longint'(w_arr[k*lanes+j]) * longint'(px_arr[k*lanes+j])) >>> shift;
            acc += s;
            if (acc > hi) begin acc = hi; sat = 1; end
            else if (acc < lo) begin acc = lo; sat = 1; end
        end
        acc += c_bias;
        if (acc > hi) begin acc = hi; sat = 1; end
        else if (acc < lo) begin acc = lo; sat = 1; end
        if (relu && acc < 0) acc = 0;
        res = acc;
    endfunction

    task automatic run_c(input string nm, input bit relu);
        exp_t   ex;
        longint r;
        bit     s;
        int     n;
        model(NC, LC, 3, 26, relu, r, s);
        q_c.push_back('{r, s});
        c_wx[WW-1:0] = WW'(c_bias);
        for (int i = 0; i < NC; i++) begin
            c_wx[WW*(i+1) +: WW] = WW'(w_arr[i]);
            c_px[PW*i +: PW]     = PW'(px_arr[i]);
        end
        c_relu = relu;
        @(negedge clk);
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        n = 0;
        while (!c_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 115);
        ex = q_c.pop_front();
        chk({nm, " out"}, c_out, ex.res);
        chk({nm, " sat"}, c_sat, ex.sat);
        c_ready = 1'b1;
        @(negedge clk);
        c_ready = 1'b0;
        chk({nm, " busy after"}, c_busy, 0);
    endtask

    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nv;
        vecs.push_back('{"ones",     1,       1,    0,       0, 1,         0, 1,       0});
        vecs.push_back('{"neg",      -2,      3,    10,      0, -74,       0, -74,     0});
        vecs.push_back('{"neg_relu", -2,      3,    10,      1, 0,         0, 0,       0});
        vecs.push_back('{"pos_sat",  262143,  1023, 0,       0, 33554431,  1, 524287,  1});
        vecs.push_back('{"neg_sat",  -262144, 1023, 0,       0, -33554432, 1, -524288, 1});
        vecs.push_back('{"mix",      5,       7,    -3,      0, 487,       0, 487,     0});
        vecs.push_back('{"relu_big", -1,      1023, 0,       1, 0,         0, 0,       0});
        vecs.push_back('{"zero_px",  100,     0,    -5,      0, -5,        0, -5,      0});
        vecs.push_back('{"bias_min", 0,       0,    -262144, 0, -262144,   0, -262144, 0});
        vecs.push_back('{"bias_sat", 37449,   1,    100,     0, 524386,    0, 524287,  1});
        vecs[0].ea = 14;
        vecs[0].eb = 14;

        rst = 1'b1;
        ab_start = 0; ab_ready = 0; ab_relu = 0; ab_wx = '0; ab_px = '0;
        c_start = 0; c_ready = 0; c_relu = 0; c_wx = '0; c_px = '0;
        repeat (3) @(negedge clk);
        chk("reset a_out", a_out, 0);
        chk("reset a_valid", a_valid, 0);
        chk("reset a_busy", a_busy, 0);
        chk("reset a_sat", a_sat, 0);
        chk("reset c_valid", c_valid, 0);
        chk("reset c_busy", c_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive_ab(vecs[i].w, vecs[i].w, vecs[i].px, vecs[i].bias, vecs[i].relu);
            run_ab(vecs[i].name, vecs[i].ea, vecs[i].sa, vecs[i].eb, vecs[i].sb, 0, 0);
        end

        // Saturate on chunk 0, then pull back: the clamp must not stick.
        drive_ab(262143, -1, 1023, 0, 0);
        run_ab("nonsticky", 33547270, 1, 517126, 1, 0, 0);

        // Long stall with a start pulse inside the window.
        drive_ab(-2, -2, 3, 10, 0);
        run_ab("stall", -74, 0, -74, 0, 10, 0);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_valid || a_busy) nv++;
        end
        chk("stall start ignored", nv, 0);

        // out_ready held high before any result exists.
        drive_ab(1, 1, 1, 0, 0);
        run_ab("early_ready", 14, 0, 14, 0, 0, 1);

        // Abort in the second RUN cycle after a saturating result.
        drive_ab(262143, 262143, 1023, 0, 0);
        run_ab("pre_abort", 33554431, 1, 524287, 1, 0, 0);
        @(negedge clk);
        ab_start = 1'b1;
        @(negedge clk);
        ab_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort a_out", a_out, 0);
        chk("abort a_valid", a_valid, 0);
        chk("abort a_busy", a_busy, 0);
        chk("abort a_sat", a_sat, 0);
        chk("abort b_out", b_out, 0);
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_valid || b_valid) nv++;
        end
        chk("abort no valid", nv, 0);
        drive_ab(5, 5, 7, -3, 0);
        run_ab("after_abort", 487, 0, 487, 0, 0, 0);

        // Default-size instance against the reference model.
        for (int i = 0; i < NC; i++) begin
            w_arr[i]  = int'($urandom_range(0, 524287)) - 262144;
            px_arr[i] = int'($urandom_range(0, 1023));
        end
        c_bias = int'($urandom_range(0, 524287)) - 262144;
        run_c("c_rand_full", 0);
        for (int i = 0; i < NC; i++) begin
            w_arr[i]  = int'($urandom_range(0, 4000)) - 2000;
            px_arr[i] = int'($urandom_range(0, 1023));
        end
        c_bias = int'($urandom_range(0, 2000)) - 1000;
        run_c("c_rand_small", 0);
        run_c("c_rand_small_relu", 1);
        for (int i = 0; i < NC; i++) begin
            w_arr[i]  = 262143;
            px_arr[i] = 1023;
        end
        c_bias = 0;
        run_c("c_max", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
